// File: rtl/procyon_slot_allocator.sv
// procyon_slot_allocator
//   Hands out and reclaims entry tags for ROB/LSQ/RS-style structures.
//   A registered busy bitmap tracks OPTN_DEPTH entries. Each cycle the
//   lowest-indexed free entry is offered as one-hot and binary. Up to
//   OPTN_FREE_PORTS entries can be released per cycle.
//
// Ports
//   clk             clock, rising-edge
//   rst             synchronous active-high reset
//   i_flush         release every entry (next state equals reset state)
//   i_alloc_en      take the offered entry this cycle
//   o_alloc_valid   an entry is offered (== !o_full)
//   o_alloc_onehot  offered entry, one-hot; zero when full
//   o_alloc_binary  offered entry, binary; zero when full
//   i_free_en       per-port free strobe
//   i_free_binary   per-port entry index, port k at [k*BINARY_WIDTH +: BINARY_WIDTH]
//   o_occupancy     busy bitmap
//   o_count         number of busy entries
//   o_full          all entries busy
//   o_empty         no entries busy
module procyon_slot_allocator #(
    parameter int OPTN_DEPTH      = 8,
    parameter int OPTN_FREE_PORTS = 2,
    parameter int BINARY_WIDTH    = (OPTN_DEPTH == 1) ? 1 : $clog2(OPTN_DEPTH),
    parameter int COUNT_WIDTH     = $clog2(OPTN_DEPTH + 1)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    i_flush,
    input  logic                                    i_alloc_en,
    output logic                                    o_alloc_valid,
    output logic [OPTN_DEPTH-1:0]                   o_alloc_onehot,
    output logic [BINARY_WIDTH-1:0]                 o_alloc_binary,
    input  logic [OPTN_FREE_PORTS-1:0]              i_free_en,
    input  logic [OPTN_FREE_PORTS*BINARY_WIDTH-1:0] i_free_binary,
    output logic [OPTN_DEPTH-1:0]                   o_occupancy,
    output logic [COUNT_WIDTH-1:0]                  o_count,
    output logic                                    o_full,
    output logic                                    o_empty
);

    logic [OPTN_DEPTH-1:0]  occupancy_q, occupancy_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;

    logic [OPTN_DEPTH-1:0]   offer_onehot;
    logic [BINARY_WIDTH-1:0] offer_binary;
    logic                    offer_found;
    logic [OPTN_DEPTH-1:0]   free_mask;
    logic [OPTN_DEPTH-1:0]   alloc_mask;

    // Offer depends only on registered occupancy, never on same-cycle
    // frees, so a freed entry is offered one cycle after it clears.
    always_comb begin
        offer_onehot = '0;
        offer_binary = '0;
        offer_found  = 1'b0;
        for (int i = 0; i < OPTN_DEPTH; i++) begin
            if (!occupancy_q[i] && !offer_found) begin
                offer_onehot[i] = 1'b1;
                offer_binary    = BINARY_WIDTH'(i);
                offer_found     = 1'b1;
            end
        end
    end

    // Indices >= OPTN_DEPTH match no bit and are dropped; duplicate
    // indices across ports simply OR together.
    always_comb begin
        free_mask = '0;
        for (int k = 0; k < OPTN_FREE_PORTS; k++) begin
            for (int i = 0; i < OPTN_DEPTH; i++) begin
                if (i_free_en[k] &&
                    (i_free_binary[k*BINARY_WIDTH +: BINARY_WIDTH] == BINARY_WIDTH'(i))) begin
                    free_mask[i] = 1'b1;
                end
            end
        end
    end

    // Acceptance uses the registered full flag; room made by a
    // same-cycle free does not count.
    assign alloc_mask = (i_alloc_en && !full_q) ? offer_onehot : '0;

    always_comb begin
        occupancy_d = (occupancy_q & ~free_mask) | alloc_mask;
        count_d     = '0;
        for (int i = 0; i < OPTN_DEPTH; i++) begin
            count_d = count_d + COUNT_WIDTH'(occupancy_d[i]);
        end
        full_d  = &occupancy_d;
        empty_d = (occupancy_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            occupancy_q <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
        end else begin
            occupancy_q <= occupancy_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
        end
    end

    assign o_alloc_valid  = !full_q;
    assign o_alloc_onehot = offer_onehot;
    assign o_alloc_binary = offer_binary;
    assign o_occupancy    = occupancy_q;
    assign o_count        = count_q;
    assign o_full         = full_q;
    assign o_empty        = empty_q;

endmodule

// File: tb/tb_procyon_slot_allocator.sv
module tb_procyon_slot_allocator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DEPTH=4, PORTS=2 instance
    logic       flush, alloc_en;
    logic       alloc_valid;
    logic [3:0] alloc_onehot;
    logic [1:0] alloc_binary;
    logic [1:0] free_en;
    logic [3:0] free_binary;
    logic [3:0] occupancy;
    logic [2:0] count;
    logic       full, empty;

    procyon_slot_allocator #(.OPTN_DEPTH(4), .OPTN_FREE_PORTS(2)) dut (
        .clk(clk), .rst(rst), .i_flush(flush), .i_alloc_en(alloc_en),
        .o_alloc_valid(alloc_valid), .o_alloc_onehot(alloc_onehot),
        .o_alloc_binary(alloc_binary), .i_free_en(free_en),
        .i_free_binary(free_binary), .o_occupancy(occupancy),
        .o_count(count), .o_full(full), .o_empty(empty)
    );

    // DEPTH=3, PORTS=1 instance (index 3 is out of range)
    logic       flush3, alloc_en3;
    logic       alloc_valid3;
    logic [2:0] alloc_onehot3;
    logic [1:0] alloc_binary3;
    logic [0:0] free_en3;
    logic [1:0] free_binary3;
    logic [2:0] occupancy3;
    logic [1:0] count3;
    logic       full3, empty3;

    procyon_slot_allocator #(.OPTN_DEPTH(3), .OPTN_FREE_PORTS(1)) dut3 (
        .clk(clk), .rst(rst), .i_flush(flush3), .i_alloc_en(alloc_en3),
        .o_alloc_valid(alloc_valid3), .o_alloc_onehot(alloc_onehot3),
        .o_alloc_binary(alloc_binary3), .i_free_en(free_en3),
        .i_free_binary(free_binary3), .o_occupancy(occupancy3),
        .o_count(count3), .o_full(full3), .o_empty(empty3)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; alloc_en = 0; free_en = 2'b00; free_binary = 4'h0;
    endtask

    task automatic state4(input string tag, input logic [3:0] occ, input logic [2:0] cnt,
                          input logic f, input logic e);
        check({tag, "_occ"},   32'(occupancy), 32'(occ));
        check({tag, "_count"}, 32'(count),     32'(cnt));
        check({tag, "_full"},  32'(full),      32'(f));
        check({tag, "_empty"}, 32'(empty),     32'(e));
    endtask

    initial begin
        idle();
        flush3 = 0; alloc_en3 = 0; free_en3 = 1'b0; free_binary3 = 2'd0;
        rst = 1;
        #1;
        tick();
        tick();
        rst = 0;

        // Reset state
        state4("reset", 4'b0000, 3'd0, 1'b0, 1'b1);
        check("reset_valid",  32'(alloc_valid),  32'd1);
        check("reset_onehot", 32'(alloc_onehot), 32'h1);
        check("reset_binary", 32'(alloc_binary), 32'd0);

        // Four consecutive allocations
        alloc_en = 1;
        check("alloc0_bin", 32'(alloc_binary), 32'd0);
        check("alloc0_oh",  32'(alloc_onehot), 32'b0001);
        tick();
        check("alloc1_bin", 32'(alloc_binary), 32'd1);
        check("alloc1_oh",  32'(alloc_onehot), 32'b0010);
        check("alloc1_occ", 32'(occupancy),    32'b0001);
        tick();
        check("alloc2_bin", 32'(alloc_binary), 32'd2);
        check("alloc2_oh",  32'(alloc_onehot), 32'b0100);
        tick();
        check("alloc3_bin", 32'(alloc_binary), 32'd3);
        check("alloc3_oh",  32'(alloc_onehot), 32'b1000);
        tick();
        state4("full", 4'b1111, 3'd4, 1'b1, 1'b0);
        check("full_valid",  32'(alloc_valid),  32'd0);
        check("full_onehot", 32'(alloc_onehot), 32'h0);
        check("full_binary", 32'(alloc_binary), 32'd0);

        // Full: free 2 with alloc request -> alloc ignored
        alloc_en = 1; free_en = 2'b01; free_binary = {2'd0, 2'd2};
        tick();
        idle();
        state4("free_when_full", 4'b1011, 3'd3, 1'b0, 1'b0);
        check("free_when_full_bin", 32'(alloc_binary), 32'd2);

        // Refill, then free two entries on two ports
        alloc_en = 1;
        tick();
        idle();
        check("refill_occ", 32'(occupancy), 32'b1111);
        free_en = 2'b11; free_binary = {2'd3, 2'd1};
        tick();
        idle();
        state4("dual_free", 4'b0101, 3'd2, 1'b0, 1'b0);
        check("dual_free_bin", 32'(alloc_binary), 32'd1);

        // Reach 0011: alloc 1 -> 0111, free 2 -> 0011
        alloc_en = 1;
        tick();
        idle();
        free_en = 2'b01; free_binary = {2'd0, 2'd2};
        tick();
        idle();
        check("pre_dup_occ", 32'(occupancy), 32'b0011);

        // Both ports free 0 plus alloc (offer is 2)
        alloc_en = 1; free_en = 2'b11; free_binary = {2'd0, 2'd0};
        check("dup_offer_bin", 32'(alloc_binary), 32'd2);
        tick();
        idle();
        state4("dup_free", 4'b0110, 3'd2, 1'b0, 1'b0);
        check("dup_free_bin", 32'(alloc_binary), 32'd0);

        // Flush, alloc one, then free unallocated index 3
        flush = 1;
        tick();
        idle();
        alloc_en = 1;
        tick();
        idle();
        free_en = 2'b10; free_binary = {2'd3, 2'd0};
        tick();
        idle();
        state4("free_unalloc", 4'b0001, 3'd1, 1'b0, 1'b0);

        // Reach 0111, then flush with alloc and free
        alloc_en = 1;
        tick();
        tick();
        idle();
        check("pre_flush_occ", 32'(occupancy), 32'b0111);
        flush = 1; alloc_en = 1; free_en = 2'b01; free_binary = {2'd0, 2'd0};
        tick();
        idle();
        state4("flush", 4'b0000, 3'd0, 1'b0, 1'b1);
        check("flush_bin", 32'(alloc_binary), 32'd0);

        // Reset mid-allocation
        alloc_en = 1;
        tick();
        tick();
        check("pre_rst_occ", 32'(occupancy), 32'b0011);
        rst = 1;
        tick();
        rst = 0;
        idle();
        state4("mid_rst", 4'b0000, 3'd0, 1'b0, 1'b1);
        check("mid_rst_oh", 32'(alloc_onehot), 32'b0001);

        // DEPTH=3: fill, free out-of-range index 3, then a real free
        alloc_en3 = 1;
        tick();
        tick();
        tick();
        alloc_en3 = 0;
        check("d3_full_occ",   32'(occupancy3), 32'b111);
        check("d3_full_count", 32'(count3),     32'd3);
        check("d3_full",       32'(full3),      32'd1);
        free_en3 = 1'b1; free_binary3 = 2'd3;
        tick();
        check("d3_oor_occ",   32'(occupancy3), 32'b111);
        check("d3_oor_count", 32'(count3),     32'd3);
        free_binary3 = 2'd1;
        tick();
        free_en3 = 1'b0;
        check("d3_free_occ",  32'(occupancy3),    32'b101);
        check("d3_free_bin",  32'(alloc_binary3), 32'd1);
        check("d3_free_cnt",  32'(count3),        32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
